ring_osc_trim_cal: RTL and testbench
====================================

Name: ring_osc_trim_cal

Overview:
Closed-loop calibration controller for the ring oscillator: the on-chip counterpart to bench-side frequency measurement.
- Counts rising edges of the oscillator output over a fixed window of reference clocks.
- Steps the 26-bit thermometer trim one level at a time until the count is within tolerance of a target.
- Sits in the reference clock domain next to ring_osc; drives its trim input and observes clockp[1].

Parameters:
- WINDOW, 256: reference cycles per measurement window.
- SETTLE, 16: reference cycles waited after any trim change before measuring.
- CNT_W, 16: width of edge counter, target and meas_count.
- TOL, 1: accepted absolute error |meas_count - target|.
- MAX_ITER, 32: maximum measure/adjust iterations per calibration run.
- INIT_LEVEL, 0: trim level loaded on reset, range 0..26.

Ports:
- clock  input  1  reference clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin calibration; honoured only in IDLE or DONE.
- osc_in  input  1  ring oscillator output (clockp[1]), asynchronous to clock.
- target  input  CNT_W  desired edge count per window; sampled on accepted start.
- trim  output  26  thermometer trim to ring_osc: bits [level-1:0] = 1, the rest 0.
- level  output  5  current trim level, 0..26.
- meas_count  output  CNT_W  edge count of the last completed window.
- busy  output  1  high in SETTLE, MEASURE and EVAL.
- done  output  1  high in DONE; held until the next accepted start or reset.
- locked  output  1  last run ended within tolerance; valid while done.
- sat  output  1  last run ended at level 0 or 26 still out of tolerance.

Behaviour:
Reset values:
- State IDLE; level = INIT_LEVEL; trim = thermometer(INIT_LEVEL).
- meas_count = 0; busy, done, locked, sat = 0; iteration count = 0.
- Synchronizer flops = 0.
- Reset mid-run aborts immediately, with the same values.

osc_in path:
- Two-flop synchronizer, then a rising-edge detector (third flop); runs in every state.
- osc_in frequency must be below f_clock/2; higher frequencies are out of scope (count aliases).

State machine:
- IDLE/DONE -> SETTLE on start.
  - Latch target; clear done, locked, sat and the iteration count.
  - Level is NOT reloaded, so a restart resumes from the current trim.
- SETTLE: wait exactly SETTLE cycles -> MEASURE.
  - Edge counter cleared on entry to MEASURE.
- MEASURE: exactly WINDOW cycles.
  - Edge counter increments on each detected edge and saturates at all-ones.
  - On the last cycle, the count including that cycle's edge is copied to meas_count -> EVAL.
- EVAL (1 cycle): iteration count += 1, then the first matching rule applies:
  - |meas_count - target| <= TOL: DONE, locked = 1.
  - meas_count > target + TOL (too fast):
    - level < 26: level + 1 -> SETTLE.
    - level = 26: DONE, sat = 1.
  - meas_count < target - TOL (too slow):
    - level > 0: level - 1 -> SETTLE.
    - level = 0: DONE, sat = 1.
  - Any level change that leaves the iteration count = MAX_ITER: apply the new level, then go to DONE with locked = 0, sat = 0.
- Comparison arithmetic:
  - Done at CNT_W+1 bits.
  - target - TOL below 0 is treated as 0.
  - target + TOL is not wrapped.
- trim and level update registered at the EVAL exit; trim is always the thermometer code of level.
- start while busy is ignored; start in the same cycle as reset is ignored.
- Iteration length is SETTLE + WINDOW + 1 cycles; done rises on the cycle after the final EVAL.

Test Plan:
1. Reset with INIT_LEVEL=0, then 10 idle cycles -> trim=0, level=0, busy=0, done=0, meas_count=0.
2. Osc model with period so that 100 edges/window at every level, target=100, pulse start -> done after exactly 273 cycles, locked=1, level=0, meas_count=100.
3. Osc model giving 200-5*level edges, target=150, TOL=1, start -> level walks 0..10, done, locked=1, level=10, trim=26'h3FF, iteration count 11.
4. Same model, target=10 -> level reaches 26, done=1, sat=1, locked=0, trim=26'h3FFFFFF. Then target=300 from level 26 -> walks down to 0, sat=1.
5. Osc model giving 100 edges at even levels and 90 at odd levels, target=95, TOL=1 -> toggles between levels; after exactly 32 iterations done=1, locked=0, sat=0.
6. Reset asserted mid-MEASURE at level 7 -> next cycle busy=0, level=INIT_LEVEL, trim restored. Extra start pulses while busy -> no restart of the window counter.

Source files
------------

// File: rtl/ring_osc_trim_cal.sv
// Ring oscillator trim calibration: counts osc edges per window, steps trim
// Ports: clock/reset, start+target in; trim/level/meas_count/busy/done/locked/sat out
module ring_osc_trim_cal #(
    parameter int WINDOW     = 256,
    parameter int SETTLE     = 16,
    parameter int CNT_W      = 16,
    parameter int TOL        = 1,
    parameter int MAX_ITER   = 32,
    parameter int INIT_LEVEL = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             osc_in,
    input  logic [CNT_W-1:0] target,
    output logic [25:0]      trim,
    output logic [4:0]       level,
    output logic [CNT_W-1:0] meas_count,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             sat
);

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(MAX_ITER + 1);

    localparam logic [TW-1:0]    SETTLE_T  = TW'(SETTLE - 1);
    localparam logic [TW-1:0]    WINDOW_T  = TW'(WINDOW - 1);
    localparam logic [CNT_W:0]   TOL_X     = (CNT_W + 1)'(TOL);
    localparam logic [4:0]       INIT_LVL  = 5'(INIT_LEVEL);
    localparam logic [25:0]      INIT_TRIM = 26'((64'd1 << INIT_LEVEL) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t           state;
    logic [2:0]       sync;
    logic [CNT_W-1:0] tgt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [TW-1:0]    timer;
    logic [IW-1:0]    iter;
    logic [IW-1:0]    iter_nxt;
    logic             edge_det;
    logic [CNT_W:0]   meas_x;
    logic [CNT_W:0]   tgt_x;
    logic [CNT_W:0]   lo_x;
    logic [CNT_W:0]   hi_x;
    logic             in_tol;
    logic             too_fast;
    logic             at_limit;
    logic             last_iter;

    // sync[1] is the second synchronizer stage, sync[2] its delayed copy
    assign edge_det = sync[1] & ~sync[2];

    always_comb begin
        cnt_inc = cnt;
        if (edge_det && (cnt != '1)) begin
            cnt_inc = cnt + CNT_W'(1);
        end
    end

    // Window compare one bit wider than the counter so target+TOL never wraps
    always_comb begin
        meas_x    = {1'b0, meas_count};
        tgt_x     = {1'b0, tgt};
        lo_x      = (tgt_x >= TOL_X) ? (tgt_x - TOL_X) : '0;
        hi_x      = tgt_x + TOL_X;
        in_tol    = (meas_x >= lo_x) && (meas_x <= hi_x);
        too_fast  = meas_x > hi_x;
        at_limit  = too_fast ? (level == 5'd26) : (level == 5'd0);
        iter_nxt  = iter + IW'(1);
        last_iter = iter_nxt == IW'(MAX_ITER);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            sync       <= '0;
            tgt        <= '0;
            cnt        <= '0;
            timer      <= '0;
            iter       <= '0;
            level      <= INIT_LVL;
            trim       <= INIT_TRIM;
            meas_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            locked     <= 1'b0;
            sat        <= 1'b0;
        end else begin
            sync <= {sync[1:0], osc_in};
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state  <= S_SETTLE;
                        tgt    <= target;
                        timer  <= SETTLE_T;
                        iter   <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        locked <= 1'b0;
                        sat    <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (timer == '0) begin
                        state <= S_MEASURE;
                        cnt   <= '0;
                        timer <= WINDOW_T;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_MEASURE: begin
                    cnt <= cnt_inc;
                    if (timer == '0) begin
                        meas_count <= cnt_inc;
                        state      <= S_EVAL;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_EVAL: begin
                    iter <= iter_nxt;
                    if (in_tol) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        locked <= 1'b1;
                    end else if (at_limit) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sat   <= 1'b1;
                    end else begin
                        // Too fast adds a stage, too slow removes one
                        if (too_fast) begin
                            level <= level + 5'd1;
                            trim  <= {trim[24:0], 1'b1};
                        end else begin
                            level <= level - 5'd1;
                            trim  <= {1'b0, trim[25:1]};
                        end
                        if (last_iter) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SETTLE;
                            timer <= SETTLE_T;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_trim_cal.sv
// Bench for ring_osc_trim_cal: iteration-level model, per-cycle compare
// Window widened to 512 so that 200 edges per window stay below f_clock/2
module tb_ring_osc_trim_cal;

    localparam int WINDOW     = 512;
    localparam int SETTLE     = 16;
    localparam int CNT_W      = 16;
    localparam int TOL        = 1;
    localparam int MAX_ITER   = 32;
    localparam int INIT_LEVEL = 0;
    localparam int L          = SETTLE + WINDOW + 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             osc_in;
    logic [CNT_W-1:0] target;
    logic [25:0]      trim;
    logic [4:0]       level;
    logic [CNT_W-1:0] meas_count;
    logic             busy;
    logic             done;
    logic             locked;
    logic             sat;

    ring_osc_trim_cal #(
        .WINDOW    (WINDOW),
        .SETTLE    (SETTLE),
        .CNT_W     (CNT_W),
        .TOL       (TOL),
        .MAX_ITER  (MAX_ITER),
        .INIT_LEVEL(INIT_LEVEL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .osc_in    (osc_in),
        .target    (target),
        .trim      (trim),
        .level     (level),
        .meas_count(meas_count),
        .busy      (busy),
        .done      (done),
        .locked    (locked),
        .sat       (sat)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int e_level;
    int e_meas;
    bit e_busy;
    bit e_done;
    bit e_locked;
    bit e_sat;
    int m_iter;
    int m_cycles;

    function automatic logic [25:0] thermo(input int l);
        logic [25:0] t;
        t = '0;
        for (int i = 0; i < 26; i++) begin
            if (i < l) t[i] = 1'b1;
        end
        return t;
    endfunction

    // Edge count the oscillator model produces at a given level
    function automatic int edges(input int mode, input int l);
        if (mode == 0) return 100;
        if (mode == 1) return 200 - 5 * l;
        return (l % 2 == 0) ? 100 : 90;
    endfunction

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("level", 32'(level), e_level);
            chk("trim", 32'(trim), 32'(thermo(e_level)));
            chk("meas_count", 32'(meas_count), e_meas);
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("locked", 32'(locked), 32'(e_locked));
            chk("sat", 32'(sat), 32'(e_sat));
            if (errors > 60) finish_sim();
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_reset();
        e_level  = INIT_LEVEL;
        e_meas   = 0;
        e_busy   = 1'b0;
        e_done   = 1'b0;
        e_locked = 1'b0;
        e_sat    = 1'b0;
    endtask

    // One calibration run; r counts edges since the iteration began
    task automatic run_cal(input int tgt, input int mode,
                           input int abort_lvl, input bit extra);
        int r;
        int n;
        int a;
        bit fin;
        m_iter   = 0;
        m_cycles = 0;
        start    = 1'b1;
        target   = CNT_W'(tgt);
        tick();
        start    = 1'b0;
        e_busy   = 1'b1;
        e_done   = 1'b0;
        e_locked = 1'b0;
        e_sat    = 1'b0;
        r   = 0;
        n   = edges(mode, e_level);
        fin = 1'b0;
        while (!fin) begin
            a = r + 1;
            osc_in = (a >= SETTLE + 8) && (a < SETTLE + 8 + 2 * n)
                     && (((a - SETTLE - 8) % 2) == 0);
            start = extra && (r == 5 || r == SETTLE + 40);
            if (start) target = CNT_W'(999);
            if (abort_lvl >= 0 && e_level == abort_lvl
                && r == SETTLE + 100) begin
                reset = 1'b1;
                tick();
                reset  = 1'b0;
                start  = 1'b0;
                osc_in = 1'b0;
                exp_reset();
                return;
            end
            tick();
            r++;
            m_cycles++;
            if (r == L - 1) e_meas = n;
            if (r == L) begin
                m_iter++;
                if ((n - tgt <= TOL) && (tgt - n <= TOL)) begin
                    fin = 1'b1;
                    e_locked = 1'b1;
                end else if (n > tgt + TOL) begin
                    if (e_level < 26) e_level++;
                    else begin
                        fin = 1'b1;
                        e_sat = 1'b1;
                    end
                end else begin
                    if (e_level > 0) e_level--;
                    else begin
                        fin = 1'b1;
                        e_sat = 1'b1;
                    end
                end
                if (!fin && m_iter == MAX_ITER) fin = 1'b1;
                if (fin) begin
                    e_busy = 1'b0;
                    e_done = 1'b1;
                end
                r = 0;
                n = edges(mode, e_level);
            end
        end
        osc_in = 1'b0;
        start  = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        osc_in = 1'b0;
        target = '0;
        tick();
        tick();
        reset = 1'b0;
        exp_reset();
        chk_en = 1'b1;

        // 1: idle after reset
        repeat (10) tick();
        chk("t1 trim", 32'(trim), 32'h0);
        chk("t1 level", 32'(level), 32'd0);
        chk("t1 busy", 32'(busy), 32'd0);

        // 2: constant 100 edges, immediate lock
        run_cal(100, 0, -1, 1'b0);
        chk("t2 cycles", m_cycles, 32'd529);
        chk("t2 locked", 32'(locked), 32'd1);
        chk("t2 meas", 32'(meas_count), 32'd100);
        chk("t2 level", 32'(level), 32'd0);
        repeat (3) tick();

        // 3: 200-5*level, target 150 -> lock at level 10
        run_cal(150, 1, -1, 1'b0);
        chk("t3 level", 32'(level), 32'd10);
        chk("t3 trim", 32'(trim), 32'h3FF);
        chk("t3 locked", 32'(locked), 32'd1);
        chk("t3 iter", m_iter, 32'd11);

        // 4a: target 10 -> saturate at 26
        run_cal(10, 1, -1, 1'b0);
        chk("t4a level", 32'(level), 32'd26);
        chk("t4a trim", 32'(trim), 32'h3FFFFFF);
        chk("t4a sat", 32'(sat), 32'd1);
        chk("t4a locked", 32'(locked), 32'd0);
        chk("t4a iter", m_iter, 32'd17);

        // 4b: target 300 -> walk down to 0
        run_cal(300, 1, -1, 1'b0);
        chk("t4b level", 32'(level), 32'd0);
        chk("t4b sat", 32'(sat), 32'd1);
        chk("t4b iter", m_iter, 32'd27);

        // 5: oscillating counts run out of iterations
        run_cal(95, 2, -1, 1'b0);
        chk("t5 iter", m_iter, 32'd32);
        chk("t5 done", 32'(done), 32'd1);
        chk("t5 locked", 32'(locked), 32'd0);
        chk("t5 sat", 32'(sat), 32'd0);
        chk("t5 level", 32'(level), 32'd0);

        // 6: ignored start pulses, then reset mid-measure at level 7
        run_cal(165, 1, 7, 1'b1);
        chk("t6 busy", 32'(busy), 32'd0);
        chk("t6 level", 32'(level), 32'd0);
        chk("t6 trim", 32'(trim), 32'h0);

        // start coinciding with reset is dropped
        reset  = 1'b1;
        start  = 1'b1;
        target = CNT_W'(50);
        tick();
        reset = 1'b0;
        start = 1'b0;
        repeat (5) tick();
        chk("t6 start+reset busy", 32'(busy), 32'd0);

        chk_en = 1'b0;
        finish_sim();
    end

endmodule
